// File: rtl/ioctl_pkg.sv
// Shared definitions for the ioctl download path: FSM encoding and default
// timing constants, common to the streamer and the core-side decoder.
package ioctl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEAD  = 3'd1,
        ST_FETCH = 3'd2,
        ST_WRITE = 3'd3,
        ST_GAP   = 3'd4,
        ST_TAIL  = 3'd5,
        ST_DONE  = 3'd6
    } ioctl_state_t;

    localparam int unsigned IOCTL_ADDR_W   = 25;
    localparam int unsigned IOCTL_WR_GAP   = 4;
    localparam int unsigned IOCTL_LEAD_CYC = 2;
    localparam int unsigned IOCTL_TAIL_CYC = 2;
    localparam int unsigned PACE_W         = 8;

    // GAP clocks after the WRITE clock: FETCH and WRITE take the other two of
    // each wr-to-wr period; GAP always lasts at least one clock.
    function automatic int unsigned gap_hold_cycles(input int unsigned wr_gap);
        return (wr_gap > 3) ? wr_gap - 2 : 1;
    endfunction

endpackage

// File: rtl/ioctl_pace_cnt.sv
// Loadable down counter; terminal count flags when the loaded interval has elapsed.
module ioctl_pace_cnt
    import ioctl_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic [PACE_W-1:0] i_value,
    output logic              o_tc_c
);

    logic [PACE_W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_value;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - PACE_W'(1);
        end
    end

    assign o_tc_c = (r_cnt == '0);

endmodule

// File: rtl/ioctl_dl_streamer.sv
// Streams a byte image from a valid/ready source onto a core's ioctl download
// port, pacing writes and honouring ioctl_wait.
module ioctl_dl_streamer
    import ioctl_pkg::*;
#(
    parameter int unsigned ADDR_W   = IOCTL_ADDR_W,
    parameter int unsigned WR_GAP   = IOCTL_WR_GAP,
    parameter int unsigned LEAD_CYC = IOCTL_LEAD_CYC,
    parameter int unsigned TAIL_CYC = IOCTL_TAIL_CYC
) (
    input  logic              clk_48,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [7:0]        index_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [ADDR_W-1:0] length_i,
    input  logic              src_valid,
    input  logic [7:0]        src_data,
    output logic              src_ready,
    input  logic              ioctl_wait,
    output logic              ioctl_download,
    output logic [7:0]        ioctl_index,
    output logic              ioctl_wr,
    output logic [ADDR_W-1:0] ioctl_addr,
    output logic [7:0]        ioctl_dout,
    output logic              busy,
    output logic              done
);

    localparam int unsigned       GAP_CYC = gap_hold_cycles(WR_GAP);
    localparam logic [PACE_W-1:0] LEAD_LD = PACE_W'(LEAD_CYC - 1);
    localparam logic [PACE_W-1:0] GAP_LD  = PACE_W'(GAP_CYC - 1);
    localparam logic [PACE_W-1:0] TAIL_LD = PACE_W'(TAIL_CYC - 1);

    ioctl_state_t      r_state;
    ioctl_state_t      w_state_nxt;
    logic [7:0]        r_index;
    logic [7:0]        r_dout;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_length;
    logic [ADDR_W-1:0] r_sent;
    logic [ADDR_W-1:0] r_addr;
    logic              r_download;
    logic              r_busy;
    logic              r_done;
    logic              w_load;
    logic [PACE_W-1:0] w_load_val;
    logic              w_tc;
    logic              w_pop;
    logic              w_wr;
    logic              w_accept;
    logic              w_active_nxt;

    ioctl_pace_cnt u_pace (
        .i_clk   (clk_48),
        .i_rst   (reset),
        .i_load  (w_load),
        .i_value (w_load_val),
        .o_tc_c  (w_tc)
    );

    always_ff @(posedge clk_48 or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_load       = 1'b0;
        w_load_val   = '0;
        w_pop        = 1'b0;
        w_wr         = 1'b0;
        w_accept     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_load      = 1'b1;
                    w_load_val  = LEAD_LD;
                    w_state_nxt = ST_LEAD;
                end
            end
            ST_LEAD: begin
                if (w_tc) begin
                    if ((r_length == '0) || abort) begin
                        w_load      = 1'b1;
                        w_load_val  = TAIL_LD;
                        w_state_nxt = ST_TAIL;
                    end else begin
                        w_state_nxt = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                if (src_valid) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // Write only in a clock the core is not stalling.
                if (!ioctl_wait) begin
                    w_wr        = 1'b1;
                    w_load      = 1'b1;
                    w_load_val  = GAP_LD;
                    w_state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                if (w_tc) begin
                    if ((r_sent == r_length) || abort) begin
                        w_load      = 1'b1;
                        w_load_val  = TAIL_LD;
                        w_state_nxt = ST_TAIL;
                    end else begin
                        w_state_nxt = ST_FETCH;
                    end
                end
            end
            ST_TAIL: begin
                if (w_tc) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_active_nxt = (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_DONE);
    end

    // Transfer parameters, captured byte/address and the window flags.
    always_ff @(posedge clk_48 or posedge reset) begin
        if (reset) begin
            r_index    <= '0;
            r_base     <= '0;
            r_length   <= '0;
            r_sent     <= '0;
            r_addr     <= '0;
            r_dout     <= '0;
            r_download <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_index  <= index_i;
                r_base   <= base_i;
                r_length <= length_i;
                r_sent   <= '0;
            end
            if (w_pop) begin
                r_dout <= src_data;
                r_addr <= r_base + r_sent;
            end
            if (w_wr) begin
                r_sent <= r_sent + ADDR_W'(1);
            end
            r_download <= w_active_nxt;
            r_busy     <= w_active_nxt;
            r_done     <= (w_state_nxt == ST_DONE);
        end
    end

    assign src_ready      = w_pop;
    assign ioctl_wr       = w_wr;
    assign ioctl_download = r_download;
    assign ioctl_index    = r_index;
    assign ioctl_addr     = r_addr;
    assign ioctl_dout     = r_dout;
    assign busy           = r_busy;
    assign done           = r_done;

endmodule

// File: tb/tb_ioctl_dl_streamer.sv
// Directed self-checking bench for ioctl_dl_streamer with default parameters.
module tb_ioctl_dl_streamer;

    logic        clk_48;
    logic        reset;
    logic        start;
    logic        abort;
    logic [7:0]  index_i;
    logic [24:0] base_i;
    logic [24:0] length_i;
    logic        src_valid;
    logic [7:0]  src_data;
    logic        src_ready;
    logic        ioctl_wait;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int src_idx = 0;
    logic [24:0] wr_addr_q[$];
    logic [7:0]  wr_dout_q[$];
    int          wr_cyc_q[$];
    int wr_in_wait = 0;
    int dl_cnt = 0;
    int pop_cnt = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int busy_at_done = 0;

    ioctl_dl_streamer dut (
        .clk_48         (clk_48),
        .reset          (reset),
        .start          (start),
        .abort          (abort),
        .index_i        (index_i),
        .base_i         (base_i),
        .length_i       (length_i),
        .src_valid      (src_valid),
        .src_data       (src_data),
        .src_ready      (src_ready),
        .ioctl_wait     (ioctl_wait),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .busy           (busy),
        .done           (done)
    );

    initial clk_48 = 1'b0;
    always #5 clk_48 = ~clk_48;

    function automatic logic [7:0] src_byte(input int i);
        return 8'((i * 37 + 5) % 256);
    endfunction

    assign src_data = src_byte(src_idx);

    always @(posedge clk_48) begin
        cyc <= cyc + 1;
        if (src_valid && src_ready) src_idx <= src_idx + 1;
    end

    // Event recorder, sampled mid-cycle.
    always @(negedge clk_48) begin
        if (ioctl_wr) begin
            wr_addr_q.push_back(ioctl_addr);
            wr_dout_q.push_back(ioctl_dout);
            wr_cyc_q.push_back(cyc);
            if (ioctl_wait) wr_in_wait = wr_in_wait + 1;
        end
        if (ioctl_download) dl_cnt = dl_cnt + 1;
        if (src_ready) pop_cnt = pop_cnt + 1;
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
            if (busy) busy_at_done = busy_at_done + 1;
        end
    end

    task automatic pulse_start(input logic [7:0] idx, input logic [24:0] base,
                               input logic [24:0] len, output int s);
        @(posedge clk_48); #1;
        index_i = idx; base_i = base; length_i = len; start = 1'b1;
        @(posedge clk_48); #1;
        start = 1'b0;
        s = cyc;
    endtask

    task automatic wait_done(input int d0, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_48);
            if (done_cnt > d0) begin
                timed_out = 1'b0;
                break;
            end
        end
        @(posedge clk_48); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0; index_i = '0; base_i = '0;
        length_i = '0; src_valid = 1'b1; ioctl_wait = 1'b0;
        repeat (3) @(negedge clk_48);
        checks++; if ({ioctl_download, ioctl_wr, busy, done, src_ready} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 00000", {ioctl_download, ioctl_wr, busy, done, src_ready});
        end
        checks++; if (ioctl_addr !== 25'h0 || ioctl_dout !== 8'h0 || ioctl_index !== 8'h0) begin
            errors++; $display("FAIL reset_data: got addr=%h dout=%h idx=%h expected zeros", ioctl_addr, ioctl_dout, ioctl_index);
        end
        @(posedge clk_48); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk_48);
        #1;
    endtask

    task automatic test_basic();
        int s, w0, d0, dl0, p0, i0;
        bit to;
        w0 = wr_addr_q.size(); d0 = done_cnt; dl0 = dl_cnt; p0 = pop_cnt; i0 = src_idx;
        pulse_start(8'h03, 25'h100, 25'd4, s);
        wait_done(d0, to);
        checks++; if (to) begin errors++; $display("FAIL basic_timeout: got no done expected done"); end
        checks++; if (wr_addr_q.size() - w0 !== 4) begin
            errors++; $display("FAIL basic_wr_count: got %0d expected 4", wr_addr_q.size() - w0);
        end
        for (int k = 0; k < 4; k++) begin
            if (w0 + k < wr_addr_q.size()) begin
                checks++; if (wr_addr_q[w0+k] !== 25'(32'h100 + k)) begin
                    errors++; $display("FAIL basic_addr[%0d]: got %h expected %h", k, wr_addr_q[w0+k], 25'(32'h100 + k));
                end
                checks++; if (wr_dout_q[w0+k] !== src_byte(i0 + k)) begin
                    errors++; $display("FAIL basic_dout[%0d]: got %h expected %h", k, wr_dout_q[w0+k], src_byte(i0 + k));
                end
                checks++; if (wr_cyc_q[w0+k] - s + 1 !== 4 + 4 * k) begin
                    errors++; $display("FAIL basic_wr_time[%0d]: got %0d expected %0d", k, wr_cyc_q[w0+k] - s + 1, 4 + 4 * k);
                end
            end
        end
        checks++; if (dl_cnt - dl0 !== 20) begin errors++; $display("FAIL basic_dl_len: got %0d expected 20", dl_cnt - dl0); end
        checks++; if (done_cnt - d0 !== 1 || done_cyc - s + 1 !== 21) begin
            errors++; $display("FAIL basic_done: got count=%0d at=%0d expected count=1 at=21", done_cnt - d0, done_cyc - s + 1);
        end
        checks++; if (pop_cnt - p0 !== 4) begin errors++; $display("FAIL basic_pops: got %0d expected 4", pop_cnt - p0); end
        checks++; if (ioctl_index !== 8'h03) begin errors++; $display("FAIL basic_index: got %h expected 03", ioctl_index); end
    endtask

    task automatic test_zero_len();
        int s, w0, d0, dl0, p0;
        bit to;
        w0 = wr_addr_q.size(); d0 = done_cnt; dl0 = dl_cnt; p0 = pop_cnt;
        pulse_start(8'h11, 25'h55, 25'd0, s);
        wait_done(d0, to);
        checks++; if (to) begin errors++; $display("FAIL zero_timeout: got no done expected done"); end
        checks++; if (dl_cnt - dl0 !== 4) begin errors++; $display("FAIL zero_dl_len: got %0d expected 4", dl_cnt - dl0); end
        checks++; if (wr_addr_q.size() - w0 !== 0 || pop_cnt - p0 !== 0) begin
            errors++; $display("FAIL zero_activity: got wr=%0d pops=%0d expected 0 0", wr_addr_q.size() - w0, pop_cnt - p0);
        end
        checks++; if (done_cyc - s + 1 !== 5) begin errors++; $display("FAIL zero_done_time: got %0d expected 5", done_cyc - s + 1); end
    endtask

    task automatic test_wait();
        int s, w0, d0, dl0, i0, ww0, changes;
        logic [24:0] hold_addr;
        logic [7:0]  hold_dout;
        w0 = wr_addr_q.size(); d0 = done_cnt; dl0 = dl_cnt; i0 = src_idx; ww0 = wr_in_wait;
        changes = 0; hold_addr = '0; hold_dout = '0;
        pulse_start(8'h22, 25'h40, 25'd1, s);
        for (int n = 2; n <= 22; n++) begin
            @(posedge clk_48); #1;
            ioctl_wait = (n >= 4 && n <= 13);
            @(negedge clk_48);
            if (n == 4) begin
                hold_addr = ioctl_addr; hold_dout = ioctl_dout;
            end else if (n > 4 && n <= 14 && (ioctl_addr !== hold_addr || ioctl_dout !== hold_dout)) begin
                changes++;
            end
        end
        ioctl_wait = 1'b0;
        checks++; if (wr_in_wait - ww0 !== 0) begin errors++; $display("FAIL wait_wr_during_wait: got %0d expected 0", wr_in_wait - ww0); end
        checks++; if (wr_addr_q.size() - w0 !== 1) begin
            errors++; $display("FAIL wait_wr_count: got %0d expected 1", wr_addr_q.size() - w0);
        end else begin
            checks++; if (wr_cyc_q[w0] - s + 1 !== 14) begin
                errors++; $display("FAIL wait_wr_time: got %0d expected 14", wr_cyc_q[w0] - s + 1);
            end
            checks++; if (wr_addr_q[w0] !== 25'h40 || wr_dout_q[w0] !== src_byte(i0)) begin
                errors++; $display("FAIL wait_wr_data: got %h/%h expected 0000040/%h", wr_addr_q[w0], wr_dout_q[w0], src_byte(i0));
            end
        end
        checks++; if (changes !== 0) begin errors++; $display("FAIL wait_hold: got %0d changes expected 0", changes); end
        checks++; if (done_cnt - d0 !== 1 || done_cyc - s + 1 !== 19 || dl_cnt - dl0 !== 18) begin
            errors++; $display("FAIL wait_done: got count=%0d at=%0d dl=%0d expected 1 19 18", done_cnt - d0, done_cyc - s + 1, dl_cnt - dl0);
        end
    endtask

    task automatic test_wrap();
        int s, w0, d0;
        bit to;
        logic [24:0] exp_a [3];
        exp_a[0] = 25'h1FFFFFE; exp_a[1] = 25'h1FFFFFF; exp_a[2] = 25'h0000000;
        w0 = wr_addr_q.size(); d0 = done_cnt;
        pulse_start(8'h33, 25'h1FFFFFE, 25'd3, s);
        wait_done(d0, to);
        checks++; if (to) begin errors++; $display("FAIL wrap_timeout: got no done expected done"); end
        checks++; if (wr_addr_q.size() - w0 !== 3) begin
            errors++; $display("FAIL wrap_wr_count: got %0d expected 3", wr_addr_q.size() - w0);
        end
        for (int k = 0; k < 3; k++) begin
            if (w0 + k < wr_addr_q.size()) begin
                checks++; if (wr_addr_q[w0+k] !== exp_a[k]) begin
                    errors++; $display("FAIL wrap_addr[%0d]: got %h expected %h", k, wr_addr_q[w0+k], exp_a[k]);
                end
            end
        end
        checks++; if (done_cyc - s + 1 !== 17) begin errors++; $display("FAIL wrap_done_time: got %0d expected 17", done_cyc - s + 1); end
    endtask

    task automatic test_abort();
        int s, w0, d0, dl0, p0;
        w0 = wr_addr_q.size(); d0 = done_cnt; dl0 = dl_cnt; p0 = pop_cnt;
        pulse_start(8'h5A, 25'h1000, 25'd8, s);
        for (int n = 2; n <= 18; n++) begin
            @(posedge clk_48); #1;
            abort = (n >= 9 && n <= 16);
            if (n == 6) begin
                index_i = 8'hEE; base_i = 25'h777; length_i = 25'd1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        abort = 1'b0;
        checks++; if (wr_addr_q.size() - w0 !== 2 || pop_cnt - p0 !== 2) begin
            errors++; $display("FAIL abort_count: got wr=%0d pops=%0d expected 2 2", wr_addr_q.size() - w0, pop_cnt - p0);
        end else begin
            checks++; if (wr_addr_q[w0] !== 25'h1000 || wr_addr_q[w0+1] !== 25'h1001) begin
                errors++; $display("FAIL abort_addr: got %h %h expected 1000 1001", wr_addr_q[w0], wr_addr_q[w0+1]);
            end
        end
        checks++; if (done_cnt - d0 !== 1 || done_cyc - s + 1 !== 13 || dl_cnt - dl0 !== 12) begin
            errors++; $display("FAIL abort_done: got count=%0d at=%0d dl=%0d expected 1 13 12", done_cnt - d0, done_cyc - s + 1, dl_cnt - dl0);
        end
        checks++; if (ioctl_index !== 8'h5A) begin errors++; $display("FAIL abort_ignored_start: got index %h expected 5a", ioctl_index); end
        checks++; if (busy_at_done !== 0) begin errors++; $display("FAIL busy_with_done: got %0d expected 0", busy_at_done); end
    endtask

    task automatic test_reset_mid();
        int s, w0, d0, dl0;
        bit to;
        pulse_start(8'h44, 25'h200, 25'd4, s);
        for (int n = 2; n <= 5; n++) begin
            @(posedge clk_48); #1;
        end
        checks++; if (ioctl_download !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL rst_mid_pre: got dl=%b busy=%b expected 1 1", ioctl_download, busy);
        end
        reset = 1'b1;
        #1;
        checks++; if ({ioctl_download, ioctl_wr, busy, done} !== 4'b0) begin
            errors++; $display("FAIL rst_mid_ctrl: got %b expected 0000", {ioctl_download, ioctl_wr, busy, done});
        end
        checks++; if (ioctl_addr !== 25'h0 || ioctl_index !== 8'h0) begin
            errors++; $display("FAIL rst_mid_regs: got addr=%h idx=%h expected 0 0", ioctl_addr, ioctl_index);
        end
        repeat (2) @(posedge clk_48);
        #1;
        reset = 1'b0;
        w0 = wr_addr_q.size(); d0 = done_cnt; dl0 = dl_cnt;
        pulse_start(8'h66, 25'h300, 25'd2, s);
        wait_done(d0, to);
        checks++; if (to) begin errors++; $display("FAIL rst_mid_timeout: got no done expected done"); end
        checks++; if (wr_addr_q.size() - w0 !== 2) begin
            errors++; $display("FAIL rst_mid_wr_count: got %0d expected 2", wr_addr_q.size() - w0);
        end else begin
            checks++; if (wr_addr_q[w0] !== 25'h300 || wr_addr_q[w0+1] !== 25'h301) begin
                errors++; $display("FAIL rst_mid_addr: got %h %h expected 300 301", wr_addr_q[w0], wr_addr_q[w0+1]);
            end
        end
        checks++; if (done_cyc - s + 1 !== 13 || dl_cnt - dl0 !== 12) begin
            errors++; $display("FAIL rst_mid_done: got at=%0d dl=%0d expected 13 12", done_cyc - s + 1, dl_cnt - dl0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_wait();
        test_wrap();
        test_abort();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
